// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Holds the controller state encoding and the index-width calculation.
// Imported by the top level; contains no logic of its own.
package serial_adder_pkg;

    // Controller states: waiting for a request, or stepping through digits.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of the digit index for n digits: ceil(log2(n)), at least 1 bit.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// D-bit ripple-carry adder slice built from full-adder cells.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.

// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// D-bit ripple of full-adder cells. c_msb is the carry into the top bit of
// the slice, which the caller needs for signed-overflow detection.
module digit_adder #(
    parameter int D = 1
) (
    input  logic [D-1:0] a_d,
    input  logic [D-1:0] b_d,
    input  logic         c_in,
    output logic [D-1:0] s_d,
    output logic         c_out,
    output logic         c_msb
);

    // c[i] is the carry into bit i of the slice.
    logic [D:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < D; i++) begin : g_cell
        full_adder u_fa (
            .a  (a_d[i]),
            .b  (b_d[i]),
            .ci (c[i]),
            .s  (s_d[i]),
            .co (c[i+1])
        );
    end

    assign c_out = c[D];
    assign c_msb = c[D-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: sum/cout/ovf of a + b + cin, D bits per clock.
// Latency: N = W/D cycles from accepted start to the one-cycle done pulse.
// Backpressure: start is ignored while busy; one addition per N+1 cycles max.
module serial_adder #(
    parameter int W = 8,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    import serial_adder_pkg::*;

    localparam int N  = W / D;
    localparam int IW = idx_width(N);

    // Reject parameter combinations that cannot be split into whole digits.
    if (W < 2 || D < 1 || D > W || (W % D) != 0) begin : g_param_check
        $error("serial_adder: illegal parameters W=%0d D=%0d", W, D);
    end

    state_t          state_q;
    state_t          state_d;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            carry_q;
    logic            cout_q;
    logic            ovf_q;
    logic            done_q;
    logic [IW-1:0]   idx_q;

    logic            accept;
    logic            last;
    logic [D-1:0]    a_dig;
    logic [D-1:0]    b_dig;
    logic [D-1:0]    s_dig;
    logic            dig_cout;
    logic            dig_cmsb;

    // Current digit of each latched operand.
    assign a_dig = a_q[int'(idx_q)*D +: D];
    assign b_dig = b_q[int'(idx_q)*D +: D];

    digit_adder #(
        .D (D)
    ) u_digit (
        .a_d   (a_dig),
        .b_d   (b_dig),
        .c_in  (carry_q),
        .s_d   (s_dig),
        .c_out (dig_cout),
        .c_msb (dig_cmsb)
    );

    // Next-state logic: accept a request in IDLE, leave RUN after the last digit.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx_q == IW'(N - 1)) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: latch operands on accept, then write one sum digit per cycle.
    // cout/ovf only move on the last digit so they stay valid until the next
    // result lands; sum is overwritten digit by digit rather than cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            done_q <= last;
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= cin;
                idx_q   <= '0;
            end else if (state_q == RUN) begin
                sum_q[int'(idx_q)*D +: D] <= s_dig;
                carry_q                   <= dig_cout;
                if (last) begin
                    cout_q <= dig_cout;
                    ovf_q  <= dig_cmsb ^ dig_cout;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder across four W/D configurations.
// Instances: 0 = W8/D2, 1 = W8/D1, 2 = W8/D8, 3 = W4/D2.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic [3:0] start_v;
    logic [3:0] cin_v;
    logic [7:0] a_v [4];
    logic [7:0] b_v [4];

    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] cout_v;
    logic [3:0] ovf_v;
    logic [7:0] sum_v [4];

    logic       busy0, busy1, busy2, busy3;
    logic       done0, done1, done2, done3;
    logic       cout0, cout1, cout2, cout3;
    logic       ovf0, ovf1, ovf2, ovf3;
    logic [7:0] sum0, sum1, sum2;
    logic [3:0] sum3;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.W(8), .D(2)) u_w8d2 (
        .clk (clk), .rst_n (rst_n), .start (start_v[0]),
        .a (a_v[0]), .b (b_v[0]), .cin (cin_v[0]),
        .busy (busy0), .done (done0), .sum (sum0), .cout (cout0), .ovf (ovf0)
    );

    serial_adder #(.W(8), .D(1)) u_w8d1 (
        .clk (clk), .rst_n (rst_n), .start (start_v[1]),
        .a (a_v[1]), .b (b_v[1]), .cin (cin_v[1]),
        .busy (busy1), .done (done1), .sum (sum1), .cout (cout1), .ovf (ovf1)
    );

    serial_adder #(.W(8), .D(8)) u_w8d8 (
        .clk (clk), .rst_n (rst_n), .start (start_v[2]),
        .a (a_v[2]), .b (b_v[2]), .cin (cin_v[2]),
        .busy (busy2), .done (done2), .sum (sum2), .cout (cout2), .ovf (ovf2)
    );

    serial_adder #(.W(4), .D(2)) u_w4d2 (
        .clk (clk), .rst_n (rst_n), .start (start_v[3]),
        .a (a_v[3][3:0]), .b (b_v[3][3:0]), .cin (cin_v[3]),
        .busy (busy3), .done (done3), .sum (sum3), .cout (cout3), .ovf (ovf3)
    );

    assign busy_v   = {busy3, busy2, busy1, busy0};
    assign done_v   = {done3, done2, done1, done0};
    assign cout_v   = {cout3, cout2, cout1, cout0};
    assign ovf_v    = {ovf3, ovf2, ovf1, ovf0};
    assign sum_v[0] = sum0;
    assign sum_v[1] = sum1;
    assign sum_v[2] = sum2;
    assign sum_v[3] = {4'h0, sum3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one start pulse; returns at the falling edge after acceptance.
    task automatic launch(input int sel, input logic [7:0] a, input logic [7:0] b, input logic cin);
        @(negedge clk);
        start_v[sel] = 1'b1;
        a_v[sel]     = a;
        b_v[sel]     = b;
        cin_v[sel]   = cin;
        @(negedge clk);
        start_v[sel] = 1'b0;
    endtask

    // Count falling edges until done is seen, bounded.
    task automatic wait_done(input int sel, input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done_v[sel] && lat < 64);
        check_eq({tag, ".done_seen"}, 32'(done_v[sel]), 32'd1);
    endtask

    task automatic do_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] es, input logic ec, input logic eo,
                         input int elat, input string tag);
        int lat;
        launch(sel, a, b, cin);
        check_eq({tag, ".busy_run"}, 32'(busy_v[sel]), 32'd1);
        wait_done(sel, tag, lat);
        check_eq({tag, ".lat"}, 32'(lat), 32'(elat));
        check_eq({tag, ".sum"}, 32'(sum_v[sel]), 32'(es));
        check_eq({tag, ".cout"}, 32'(cout_v[sel]), 32'(ec));
        check_eq({tag, ".ovf"}, 32'(ovf_v[sel]), 32'(eo));
        check_eq({tag, ".busy_done"}, 32'(busy_v[sel]), 32'd0);
        @(negedge clk);
        check_eq({tag, ".done_pulse"}, 32'(done_v[sel]), 32'd0);
        check_eq({tag, ".sum_hold"}, 32'(sum_v[sel]), 32'(es));
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lat;
        int pulses;
        logic [8:0] v;
        logic [7:0] sa, sb;
        logic       sc;

        rst_n   = 1'b0;
        start_v = '0;
        cin_v   = '0;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end

        // Reset state of every instance.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check_eq("rst.busy", 32'(busy_v[i]), 32'd0);
            check_eq("rst.done", 32'(done_v[i]), 32'd0);
            check_eq("rst.sum", 32'(sum_v[i]), 32'd0);
            check_eq("rst.cout", 32'(cout_v[i]), 32'd0);
            check_eq("rst.ovf", 32'(ovf_v[i]), 32'd0);
        end
        rst_n = 1'b1;

        // Basic additions across digit widths.
        do_op(0, 8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 1'b0, 4, "d2_a5_3c");
        do_op(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8, "d1_ff_01");
        do_op(1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8, "d1_7f_01");
        do_op(2, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 1, "d8_80_80");

        // cout/ovf keep the previous result while a new one is computed.
        launch(1, 8'hFF, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("hold.ovf_mid", 32'(ovf_v[1]), 32'd1);
        check_eq("hold.cout_mid", 32'(cout_v[1]), 32'd0);
        check_eq("hold.done_mid", 32'(done_v[1]), 32'd0);
        wait_done(1, "hold", lat);
        check_eq("hold.sum", 32'(sum_v[1]), 32'h00);
        check_eq("hold.cout", 32'(cout_v[1]), 32'd1);
        check_eq("hold.ovf", 32'(ovf_v[1]), 32'd0);

        // Start while busy is ignored.
        launch(0, 8'h12, 8'h34, 1'b0);
        @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0]     = 8'hFF;
        b_v[0]     = 8'hFF;
        cin_v[0]   = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, "ign", lat);
        check_eq("ign.sum", 32'(sum_v[0]), 32'h46);
        check_eq("ign.cout", 32'(cout_v[0]), 32'd0);
        check_eq("ign.ovf", 32'(ovf_v[0]), 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_v[0]) pulses++;
        end
        check_eq("ign.extra_done", 32'(pulses), 32'd0);
        check_eq("ign.busy_after", 32'(busy_v[0]), 32'd0);
        check_eq("ign.sum_after", 32'(sum_v[0]), 32'h46);

        // Asynchronous reset mid-run, after a result with cout=ovf=1.
        do_op(0, 8'hC0, 8'h80, 1'b0, 8'h40, 1'b1, 1'b1, 4, "d2_c0_80");
        launch(0, 8'hA5, 8'h3C, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst.busy", 32'(busy_v[0]), 32'd0);
        check_eq("arst.done", 32'(done_v[0]), 32'd0);
        check_eq("arst.sum", 32'(sum_v[0]), 32'd0);
        check_eq("arst.cout", 32'(cout_v[0]), 32'd0);
        check_eq("arst.ovf", 32'(ovf_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst.no_done", 32'(done_v[0]), 32'd0);
        do_op(0, 8'h0F, 8'h01, 1'b1, 8'h11, 1'b0, 1'b0, 4, "post_rst");

        // Exhaustive W=4/D=2 sweep, each start presented on the done cycle.
        @(negedge clk);
        v = 9'd0;
        start_v[3] = 1'b1;
        a_v[3]     = {4'h0, v[3:0]};
        b_v[3]     = {4'h0, v[7:4]};
        cin_v[3]   = v[8];
        for (int n = 0; n < 512; n++) begin
            v  = 9'(n);
            sa = {4'h0, v[3:0]};
            sb = {4'h0, v[7:4]};
            sc = v[8];
            @(negedge clk);
            start_v[3] = 1'b0;
            wait_done(3, "sweep", lat);
            check_eq("sweep.lat", 32'(lat), 32'd2);
            check_eq("sweep.res", {27'd0, cout_v[3], sum_v[3][3:0]},
                     32'(sa) + 32'(sb) + 32'(sc));
            if (n < 511) begin
                v = 9'(n + 1);
                start_v[3] = 1'b1;
                a_v[3]     = {4'h0, v[3:0]};
                b_v[3]     = {4'h0, v[7:4]};
                cin_v[3]   = v[8];
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
